// File: rtl/cordic_quadrant_out.sv
// Un-folds CORDIC quadrant pre-rotation into signed cos/sin and buffers results in an FWFT FIFO; optional gain stage via CORDIC_GAIN_COMP_EN.
// Latency: in_valid edge -> out_valid after CORE_LATENCY+2 edges (CORE_LATENCY+3 with CORDIC_GAIN_COMP_EN).
// Backpressure: rotator cannot stall; a result arriving at a full FIFO with no pop is dropped and flags sticky overflow.

// Generic first-word-fall-through FIFO; head visible combinationally, holds last popped word when empty.
// Latency: push at an edge -> pop_vld after that edge.
// Backpressure: push accepted when not full or when a pop happens at the same edge; otherwise drop pulses.
module cordic_fwft_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             vld_q, full_q;
  logic [WIDTH-1:0] last_q;
  logic             pop, push_ok;

  assign pop     = vld_q && pop_rdy;
  assign push_ok = push_vld && (!full_q || pop);
  assign drop    = push_vld && full_q && !pop;

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop)
      cnt_nxt = cnt + 1'b1;
    else if (!push_ok && pop)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
      last_q <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      cnt    <= cnt_nxt;
      vld_q  <= (cnt_nxt != '0);
      full_q <= (cnt_nxt == FULL_CNT);
    end
  end

  // Storage carries no reset; pop_dat only exposes it while vld_q is set.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_dat;
  end

  assign pop_vld = vld_q;
  assign full    = full_q;
  assign pop_dat = vld_q ? mem[rd_ptr] : last_q;
endmodule

module cordic_quadrant_out #(
  parameter int CORE_LATENCY = 15,
  parameter int FIFO_DEPTH   = 4,
  parameter int W            = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] x_core,
  input  logic [W-1:0] y_core,
  input  logic [1:0]   quart_core,
  output logic [W-1:0] cos_out,
  output logic [W-1:0] sin_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         fifo_full,
  output logic         overflow,
  input  logic         ovf_clr
);
  localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
    return (v == S_MIN) ? S_MAX : -v;
  endfunction

  // in_valid_q mirrors the rotator's input register; its output then trails by CORE_LATENCY more edges.
  logic                    in_valid_q;
  logic [CORE_LATENCY-1:0] vld_sr;
  logic                    tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      vld_sr     <= '0;
    end else begin
      in_valid_q <= in_valid;
      vld_sr     <= {vld_sr[CORE_LATENCY-2:0], in_valid_q};
    end
  end

  assign tap = vld_sr[CORE_LATENCY-1];

  logic signed [W-1:0] xs, ys, map_cos_d, map_sin_d;
  logic signed [W-1:0] map_cos, map_sin;
  logic                map_vld;

  assign xs = $signed(x_core);
  assign ys = $signed(y_core);

  always_comb begin
    map_cos_d = xs;
    map_sin_d = ys;
    case (quart_core)
      2'd1: begin map_cos_d = neg_sat(ys); map_sin_d = xs;          end
      2'd2: begin map_cos_d = neg_sat(xs); map_sin_d = neg_sat(ys); end
      2'd3: begin map_cos_d = ys;          map_sin_d = neg_sat(xs); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_cos <= '0;
      map_sin <= '0;
      map_vld <= 1'b0;
    end else begin
      map_vld <= tap;
      if (tap) begin
        map_cos <= map_cos_d;
        map_sin <= map_sin_d;
      end
    end
  end

  logic         res_vld;
  logic [W-1:0] res_cos, res_sin;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [14:0] GAIN = 15'sd9949;

  // 1/K in Q14; >>> floors, and the top 16 bits must agree for the result to fit W.
  function automatic logic signed [W-1:0] gain_sat(input logic signed [W-1:0] v);
    logic signed [W+14:0] p, s;
    p = v * GAIN;
    s = p >>> 14;
    if (s[W+14:W-1] == {16{s[W+14]}})
      return s[W-1:0];
    return s[W+14] ? S_MIN : S_MAX;
  endfunction

  logic signed [W-1:0] g_cos, g_sin;
  logic                g_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_cos <= '0;
      g_sin <= '0;
      g_vld <= 1'b0;
    end else begin
      g_vld <= map_vld;
      if (map_vld) begin
        g_cos <= gain_sat(map_cos);
        g_sin <= gain_sat(map_sin);
      end
    end
  end

  assign res_vld = g_vld;
  assign res_cos = g_cos;
  assign res_sin = g_sin;
`else
  assign res_vld = map_vld;
  assign res_cos = map_cos;
  assign res_sin = map_sin;
`endif

  logic drop;

  cordic_fwft_fifo #(
    .WIDTH(2 * W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (res_vld),
    .push_dat ({res_cos, res_sin}),
    .pop_rdy  (out_ready),
    .pop_vld  (out_valid),
    .pop_dat  ({cos_out, sin_out}),
    .full     (fifo_full),
    .drop     (drop)
  );

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end
endmodule

// File: tb/tb_cordic_quadrant_out.sv
// Bench for cordic_quadrant_out: emulates the rotator delay line and checks every cycle against a queue model.
`timescale 1ns/1ps
module tb_cordic_quadrant_out;
  localparam int W = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic [W-1:0] x_core, y_core, cos_out, sin_out;
  logic [1:0] quart_core;
  logic out_valid, fifo_full, overflow;

  logic signed [W-1:0] rin_x = '0, rin_y = '0;
  logic [1:0] rin_q = '0;
  logic signed [W-1:0] px [16];
  logic signed [W-1:0] py [16];
  logic [1:0] pq [16];

  int total = 0;
  int bad = 0;

  cordic_quadrant_out dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .x_core(x_core), .y_core(y_core), .quart_core(quart_core),
    .cos_out(cos_out), .sin_out(sin_out), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_full(fifo_full), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Rotator stand-in: a sample captured at edge n is on x/y/quart_core after edge n+15.
  always @(posedge clk) begin
    px[0] <= rin_x;
    py[0] <= rin_y;
    pq[0] <= rin_q;
    for (int k = 1; k < 16; k++) begin
      px[k] <= px[k-1];
      py[k] <= py[k-1];
      pq[k] <= pq[k-1];
    end
  end
  assign x_core = px[15];
  assign y_core = py[15];
  assign quart_core = pq[15];

  typedef struct { int due; int c; int s; } pend_t;
  pend_t pend[$];
  int mq_c[$], mq_s[$], mlog_c[$], mlog_s[$];
  int last_c = 0, last_s = 0, cyc = 0, first_iv = -1, first_ov = -1;
  bit m_ovf = 1'b0;

  function automatic int sat(int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int gain(int v);
`ifdef CORDIC_GAIN_COMP_EN
    return sat((v * 9949) >>> 14);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit pop, push, drop;
    int c, s;
    if (!rst_n) begin
      pend.delete(); mq_c.delete(); mq_s.delete();
      last_c = 0; last_s = 0; m_ovf = 1'b0; cyc = 0;
    end else begin
      cyc++;
      pop  = (mq_c.size() > 0) && out_ready;
      push = (pend.size() > 0) && (pend[0].due == cyc);
      drop = push && !pop && (mq_c.size() == 4);
      if (pop) begin
        last_c = mq_c.pop_front();
        last_s = mq_s.pop_front();
        mlog_c.push_back(last_c);
        mlog_s.push_back(last_s);
      end
      if (push) begin
        if (!drop) begin
          mq_c.push_back(pend[0].c);
          mq_s.push_back(pend[0].s);
        end
        void'(pend.pop_front());
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (in_valid) begin
        case (rin_q)
          2'd0: begin c = rin_x;        s = rin_y;        end
          2'd1: begin c = sat(-rin_y);  s = rin_x;        end
          2'd2: begin c = sat(-rin_x);  s = sat(-rin_y);  end
          default: begin c = rin_y;     s = sat(-rin_x);  end
        endcase
        pend.push_back('{cyc + LAT, gain(c), gain(s)});
        if (first_iv < 0) first_iv = cyc;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = mq_c.size() > 0;
    chk("out_valid", int'(out_valid), int'(ev));
    chk("fifo_full", int'(fifo_full), int'(mq_c.size() == 4));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("cos_out", int'($signed(cos_out)), ev ? mq_c[0] : last_c);
    chk("sin_out", int'($signed(sin_out)), ev ? mq_s[0] : last_s);
    if (rst_n && out_valid && first_ov < 0) first_ov = cyc;
  end

  task automatic tick(input bit v, input int x, input int y, input int q, input bit rdy, input bit clr);
    in_valid = v; rin_x = W'(x); rin_y = W'(y); rin_q = 2'(q);
    out_ready = rdy; ovf_clr = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 6; i++)
      tick($urandom_range(0, 1), $urandom_range(0, 8000), $urandom_range(0, 8000),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
    chk("rst_cos", int'(cos_out), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 0, 1, 0);

    tick(1, 1000, 200, 0, 1, 0);
    for (int i = 0; i < 24; i++) tick(0, 0, 0, 0, 1, 0);
    chk("latency", first_ov - first_iv, LAT);

    for (int q = 0; q < 4; q++) tick(1, 1000, 200, q, 1, 0);
    tick(1, -8192, 5, 2, 1, 0);
    tick(1, 7, -8192, 1, 1, 0);
    tick(1, -8192, -8192, 3, 1, 0);
    for (int i = 0; i < 25; i++) tick(0, 0, 0, 0, 1, 0);
    chk("pin_count1", mlog_c.size(), 8);
`ifndef CORDIC_GAIN_COMP_EN
    chk("pin_q0_c", mlog_c[1], 1000);  chk("pin_q0_s", mlog_s[1], 200);
    chk("pin_q1_c", mlog_c[2], -200);  chk("pin_q1_s", mlog_s[2], 1000);
    chk("pin_q2_c", mlog_c[3], -1000); chk("pin_q2_s", mlog_s[3], -200);
    chk("pin_q3_c", mlog_c[4], 200);   chk("pin_q3_s", mlog_s[4], -1000);
    chk("pin_sat_c", mlog_c[5], 8191); chk("pin_sat_s", mlog_s[5], -5);
    chk("pin_sat1_c", mlog_c[6], 8191); chk("pin_sat3_s", mlog_s[7], 8191);
`endif

    for (int i = 0; i < 6; i++) tick(1, 100 * (i + 1), -i, i % 4, 0, 0);
    for (int i = 0; i < 22; i++) tick(0, 0, 0, 0, 0, 0);
    chk("bp_model_size", mq_c.size(), 4);
    chk("bp_model_ovf", int'(m_ovf), 1);
    chk("bp_full", int'(fifo_full), 1);
    chk("bp_overflow", int'(overflow), 1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 1, 0);
    chk("pin_count2", mlog_c.size(), 12);
`ifndef CORDIC_GAIN_COMP_EN
    chk("bp_pop0_c", mlog_c[8], 100);   chk("bp_pop1_c", mlog_c[9], 1);
    chk("bp_pop2_c", mlog_c[10], -300); chk("bp_pop3_s", mlog_s[11], -400);
    chk("bp_hold_cos", int'($signed(cos_out)), -3);
`endif
    chk("bp_drained", int'(out_valid), 0);
    tick(0, 0, 0, 0, 1, 1);
    chk("clr_ovf", int'(overflow), 0);

    for (int i = 0; i < 41; i++) begin
      tick(i < 12, 10 * i, 3, i % 4, i >= 21, 0);
      if (i == 25) chk("conc_full", int'(fifo_full), 1);
    end
    chk("conc_ovf", int'(overflow), 0);
    chk("conc_model_ovf", int'(m_ovf), 0);

    for (int i = 0; i < 31; i++) tick(i < 5, 5 * i, 1, 0, 0, i == 21);
    chk("setwins_ovf", int'(overflow), 1);
    chk("setwins_model", int'(m_ovf), 1);
    tick(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 1, 0);
    chk("final_ovf", int'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
